// File: rtl/sequence_detection_scheduler.sv
// sequence_detection_scheduler
//   Round-robin scheduler that hands a shared pattern detector (PSD) to one of
//   NUM_Requester clients at a time, streams the owner's words into it, sums
//   the detector's per-cycle match count and reports the total with a
//   one-cycle done pulse.
//
// Ports
//   local_SDS_clk / local_SDS_reset : clock, synchronous active-high reset
//   local_SDS_req                   : per-requester job request (level)
//   local_SDS_compair / _length     : per-requester pattern and word count
//   local_SDS_valid / _bitstream    : owner's stream word
//   SDS_local_ready                 : word accepted this cycle
//   SDS_local_grant                 : one-hot owner
//   SDS_local_done / _error         : completion pulse and its error qualifier
//   SDS_local_total                 : saturating match total
//   SDS_PSD_newstream/_compair/_bitstream : detector restart, pattern, word
//   PSD_SDS_count                   : detector per-cycle match count
//
// state     | meaning
// ST_IDLE   | waiting for a request, arbitrating round-robin
// ST_STREAM | forwarding owner words to the detector, one per cycle
// ST_DRAIN  | two cycles letting the detector flush its last windows
// ST_REPORT | one-cycle done pulse to the owner, pointer advance
module sequence_detection_scheduler #(
    parameter int WID_Bitstream     = 8,
    parameter int WID_Compair       = 4,
    parameter int WID_Compair_count = 4,
    parameter int NUM_Requester     = 4,
    parameter int WID_Length        = 8,
    parameter int WID_Total         = 16
) (
    input  logic                                 local_SDS_clk,
    input  logic                                 local_SDS_reset,
    input  logic [NUM_Requester-1:0]             local_SDS_req,
    input  logic [NUM_Requester*WID_Compair-1:0] local_SDS_compair,
    input  logic [NUM_Requester*WID_Length-1:0]  local_SDS_length,
    input  logic                                 local_SDS_valid,
    input  logic [WID_Bitstream-1:0]             local_SDS_bitstream,
    output logic                                 SDS_local_ready,
    output logic [NUM_Requester-1:0]             SDS_local_grant,
    output logic [NUM_Requester-1:0]             SDS_local_done,
    output logic                                 SDS_local_error,
    output logic [WID_Total-1:0]                 SDS_local_total,
    output logic                                 SDS_PSD_newstream,
    output logic [WID_Compair-1:0]               SDS_PSD_compair,
    output logic [WID_Bitstream-1:0]             SDS_PSD_bitstream,
    input  logic [WID_Compair_count-1:0]         PSD_SDS_count
);

    localparam int NUM_Buffer = (WID_Compair + WID_Bitstream + WID_Bitstream - 1) / WID_Bitstream;
    localparam int W_PTR      = (NUM_Requester > 1) ? $clog2(NUM_Requester) : 1;
    localparam int W_CNT      = WID_Length + 1;
    localparam int W_SUM      = ((WID_Total > WID_Compair_count) ? WID_Total : WID_Compair_count) + 1;
    localparam logic [W_SUM-1:0] TOTAL_MAX = W_SUM'({WID_Total{1'b1}});

    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN, ST_REPORT} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [NUM_Requester-1:0] r_grant;
    logic [W_PTR-1:0]         r_owner;
    logic [W_PTR-1:0]         r_ptr;
    logic [WID_Compair-1:0]   r_pattern;
    logic [WID_Length-1:0]    r_len;
    logic [W_CNT-1:0]         r_cnt;
    logic [WID_Total-1:0]     r_total;
    logic                     r_err;

    logic                     w_found;
    logic [W_PTR-1:0]         w_win_idx;
    logic [NUM_Requester-1:0] w_win_onehot;
    logic [WID_Length-1:0]    w_win_len;
    logic [WID_Compair-1:0]   w_win_pat;
    logic                     w_short;
    logic                     w_last_word;
    logic                     w_drain_end;
    logic                     w_acc_win;
    logic [W_SUM-1:0]         w_sum;
    logic [WID_Total-1:0]     w_total_acc;
    logic [W_PTR-1:0]         w_ptr_nxt;

    // Round-robin pick: first pass covers indices at or above the pointer,
    // second pass wraps around to the indices below it.
    always_comb begin
        w_found      = 1'b0;
        w_win_idx    = '0;
        w_win_onehot = '0;
        w_win_len    = '0;
        w_win_pat    = '0;
        for (int p = 0; p < 2; p++) begin
            for (int j = 0; j < NUM_Requester; j++) begin
                if (!w_found && local_SDS_req[j] && ((p == 0) == (j >= int'(r_ptr)))) begin
                    w_found         = 1'b1;
                    w_win_idx       = W_PTR'(j);
                    w_win_onehot[j] = 1'b1;
                    w_win_len       = local_SDS_length[j*WID_Length +: WID_Length];
                    w_win_pat       = local_SDS_compair[j*WID_Compair +: WID_Compair];
                end
            end
        end
    end

    assign w_short     = (w_win_len < WID_Length'(NUM_Buffer));
    // r_cnt keeps counting through DRAIN so the last window sample lands on L+1
    assign w_last_word = (r_cnt == ({1'b0, r_len} - W_CNT'(1)));
    assign w_drain_end = (r_cnt == ({1'b0, r_len} + W_CNT'(1)));
    assign w_acc_win   = (r_cnt >= W_CNT'(NUM_Buffer + 1));
    assign w_sum       = W_SUM'(r_total) + W_SUM'(PSD_SDS_count);
    assign w_total_acc = (w_sum > TOTAL_MAX) ? '1 : w_sum[WID_Total-1:0];
    assign w_ptr_nxt   = (r_owner == W_PTR'(NUM_Requester - 1)) ? '0 : r_owner + W_PTR'(1);

    assign SDS_local_grant = r_grant;
    assign SDS_local_total = r_total;
    assign SDS_PSD_compair = r_pattern;

    always_ff @(posedge local_SDS_clk) begin
        if (local_SDS_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        SDS_local_ready   = 1'b0;
        SDS_local_done    = '0;
        SDS_local_error   = 1'b0;
        SDS_PSD_newstream = 1'b0;
        SDS_PSD_bitstream = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = w_short ? ST_REPORT : ST_STREAM;
                end
            end
            ST_STREAM: begin
                SDS_local_ready   = 1'b1;
                SDS_PSD_bitstream = local_SDS_bitstream;
                SDS_PSD_newstream = (r_cnt == '0);
                // the detector shifts every cycle, so a gap corrupts its window
                if (!local_SDS_valid) begin
                    w_state_nxt = ST_REPORT;
                end else if (w_last_word) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drain_end) begin
                    w_state_nxt = ST_REPORT;
                end
            end
            ST_REPORT: begin
                SDS_local_done  = r_grant;
                SDS_local_error = r_err;
                w_state_nxt     = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge local_SDS_clk) begin
        if (local_SDS_reset) begin
            r_grant   <= '0;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_pattern <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_total   <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant   <= w_win_onehot;
                        r_owner   <= w_win_idx;
                        r_pattern <= w_win_pat;
                        r_len     <= w_win_len;
                        r_cnt     <= '0;
                        r_total   <= '0;
                        r_err     <= w_short;
                    end
                end
                ST_STREAM: begin
                    if (local_SDS_valid) begin
                        r_cnt <= r_cnt + W_CNT'(1);
                        if (w_acc_win) begin
                            r_total <= w_total_acc;
                        end
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_cnt <= r_cnt + W_CNT'(1);
                    if (w_acc_win) begin
                        r_total <= w_total_acc;
                    end
                end
                ST_REPORT: begin
                    r_grant <= '0;
                    r_ptr   <= w_ptr_nxt;
                    r_cnt   <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sequence_detection_scheduler.md
SEQUENCE_DETECTION_SCHEDULER -- requirements
Module: sequence_detection_scheduler

Interface
REQ-001 Parameters SHALL be: WID_Bitstream, default 8, stream word width; WID_Compair, default 4, pattern width; WID_Compair_count, default 4, per-cycle detector count width; NUM_Requester, default 4, number of requesters; WID_Length, default 8, job length field width; WID_Total, default 16, accumulated result width.
REQ-002 Derived NUM_Buffer SHALL be ceil((WID_Compair+WID_Bitstream)/WID_Bitstream), matching the detector fill depth.
REQ-003 There SHALL be one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be as follows:
- local_SDS_clk, in, 1: clock.
- local_SDS_reset, in, 1: sync active-high reset.
- local_SDS_req, in, NUM_Requester: job requests, level.
- local_SDS_compair, in, NUM_Requester*WID_Compair: per-requester pattern, slice r.
- local_SDS_length, in, NUM_Requester*WID_Length: per-requester word count, slice r.
- local_SDS_valid, in, 1: granted requester's stream word valid.
- local_SDS_bitstream, in, WID_Bitstream: granted requester's stream word.
- SDS_local_ready, out, 1: word accepted this cycle.
- SDS_local_grant, out, NUM_Requester: one-hot owner.
- SDS_local_done, out, NUM_Requester: one-cycle completion pulse.
- SDS_local_error, out, 1: qualifies done; job rejected or aborted.
- SDS_local_total, out, WID_Total: match total, held until next done.
- SDS_PSD_newstream, out, 1: detector restart pulse.
- SDS_PSD_compair, out, WID_Compair: pattern to detector.
- SDS_PSD_bitstream, out, WID_Bitstream: word to detector.
- PSD_SDS_count, in, WID_Compair_count: detector per-cycle count.

Function
REQ-005 States SHALL be IDLE, STREAM, DRAIN, REPORT.
REQ-006 IDLE: on any req bit, the block SHALL grant round-robin, starting from the index after the last granted requester (index 0 first after reset), and register the grant, pattern and length.
REQ-007 If the latched length is less than NUM_Buffer, the block SHALL go to REPORT with error=1 and total=0, and SHALL NOT pulse newstream.
REQ-008 Otherwise IDLE->STREAM; newstream SHALL be 1 on the first STREAM cycle only (cycle T); SDS_PSD_compair SHALL hold the latched pattern.
REQ-009 STREAM: ready SHALL be 1 each cycle; SDS_PSD_bitstream SHALL be local_SDS_bitstream combinationally; the word counter SHALL increment per valid word.
REQ-010 The detector shifts every cycle, so valid=0 in STREAM SHALL abort the job: go to REPORT with error=1. The partial total is reported and not used.
REQ-011 After L words (cycles T..T+L-1), STREAM->DRAIN for exactly 2 cycles, then REPORT.
REQ-012 Accumulation: PSD_SDS_count SHALL be added to total on cycles T+NUM_Buffer+1 through T+L+1 inclusive (L-NUM_Buffer+1 samples); total SHALL saturate at all-ones.
REQ-013 In STREAM, SDS_PSD_bitstream SHALL be 0 when ready is 0 or outside STREAM.
REQ-014 REPORT SHALL last one cycle: done bit of owner=1, error valid, grant cleared next cycle, RR pointer updated, then IDLE.
REQ-015 A requester SHALL hold req until its done; req bits of non-owners SHALL be ignored until IDLE.
REQ-016 Requester r SHALL NOT be re-granted on the cycle after its done if another req is pending (RR fairness).
REQ-017 total SHALL clear to 0 at grant and hold its final value from done until the next grant.

Reset
REQ-018 On reset, the next edge SHALL set state=IDLE, grant=0, done=0, error=0, ready=0, newstream=0, total=0, RR pointer=0, and word counter=0.
REQ-019 Reset mid-job SHALL drop the job without a done pulse.

Verification (defaults: NUM_Buffer=2)
REQ-020 req=0001, pattern 4'hA, length 4, words 8'hAA continuous -> grant=0001, one newstream, done[0] pulse, error=0, total=12 (3 samples x 4).
REQ-021 req=1111 held -> grants in order 0001,0010,0100,1000; re-raising req[0] after its done -> requester 0 is served after 1,2,3.
REQ-022 length=1 -> done pulse, error=1, total=0, newstream never asserted.
REQ-023 valid=0 on word 2 of a length-6 job -> done pulse that cycle+1, error=1, return to IDLE.
REQ-024 reset asserted during STREAM -> all outputs 0 after the next edge, no done pulse, the next req is granted to requester 0.
REQ-025 WID_Total=3, match-dense job -> total saturates at 7.
